cell_pos_streamer: RTL

//  Read controller that sits directly downstream of one per-cell position RAM (single-port, 2-cycle read latency).
//  On start: reads address 0 (particle count N), then addresses 1..N.

---
 rtl/cell_pos_streamer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cell_pos_streamer.sv
// cell_pos_streamer: reads a particle count then particles 1..N from a
// 2-cycle-latency position RAM and streams them over valid/ready. A small
// skid FIFO with credit-limited issue absorbs consumer backpressure.
module cell_pos_streamer #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] NMAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, CNT_RD, CNT_WAIT, STREAM, FIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] pid;
    logic                  last;
  } entry_t;

  state_t                  state_q, state_d;
  logic                    wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]   n_q, n_d, rd_ptr_q, rd_ptr_d, addr_q, addr_d;
  logic                    err_q, err_d;

  // Tag pipe running alongside the RAM: [0] = 1 cycle after issue, [1] = 2.
  logic [1:0]                 tv_q, tlast_q;
  logic [1:0][ADDR_WIDTH-1:0] tpid_q;

  entry_t                  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]           wp_q, rp_q;
  logic [CW-1:0]           cnt_q;

  logic [ADDR_WIDTH-1:0]   count_raw, n_cnt, n_eff;
  logic                    clamp, cnt_ready, credit, issue, push, pop;
  logic [CW:0]             occ;
  entry_t                  head;

  assign count_raw = mem_q[ADDR_WIDTH-1:0];
  assign clamp     = count_raw > NMAX;
  assign n_cnt     = clamp ? NMAX : count_raw;
  // Count word is on mem_q during the second wait cycle; the first particle
  // read is issued in that same cycle so it overlaps the count decode.
  assign cnt_ready = (state_q == CNT_WAIT) && wait_q;
  assign n_eff     = cnt_ready ? n_cnt : n_q;
  assign occ       = (CW+1)'(cnt_q) + (CW+1)'(tv_q[0]) + (CW+1)'(tv_q[1]);
  assign credit    = occ < (CW+1)'(FIFO_DEPTH);
  assign issue     = ((state_q == STREAM) || cnt_ready) && (rd_ptr_q <= n_eff) && credit;
  assign push      = tv_q[1];
  assign head      = fifo_q[rp_q];
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid && out_ready;

  // Next-state, RAM command and count capture.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    n_d      = n_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    err_d    = err_q;
    mem_rden = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = CNT_RD;
        err_d    = 1'b0;
        rd_ptr_d = ADDR_WIDTH'(1);
      end
      CNT_RD: begin
        mem_rden = 1'b1;
        addr_d   = '0;
        wait_d   = 1'b0;
        state_d  = CNT_WAIT;
      end
      CNT_WAIT: if (!wait_q) begin
        wait_d = 1'b1;
      end else begin
        n_d     = n_cnt;
        err_d   = clamp;
        state_d = (n_cnt == '0) ? FIN : STREAM;
      end
      STREAM: if (pop && head.last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      mem_rden = 1'b1;
      addr_d   = rd_ptr_q;
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wait_q   <= 1'b0;
      n_q      <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      n_q      <= n_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Read-tag shift register and FIFO pointers/occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv_q    <= '0;
      tlast_q <= '0;
      tpid_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      tv_q      <= {tv_q[0], issue};
      tpid_q[0] <= rd_ptr_q;
      tpid_q[1] <= tpid_q[0];
      tlast_q   <= {tlast_q[0], rd_ptr_q == n_eff};
      if (push) wp_q <= (wp_q == PW'(FIFO_DEPTH-1)) ? '0 : wp_q + PW'(1);
      if (pop)  rp_q <= (rp_q == PW'(FIFO_DEPTH-1)) ? '0 : rp_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= '{data: mem_q, pid: tpid_q[1], last: tlast_q[1]};
  end

  assign busy        = (state_q == CNT_RD) || (state_q == CNT_WAIT) || (state_q == STREAM);
  assign done        = state_q == FIN;
  assign count_err   = err_q;
  assign mem_address = addr_d;
  assign mem_wren    = 1'b0;
  assign mem_data    = '0;
  assign out_data    = out_valid ? head.data : '0;
  assign out_pid     = out_valid ? head.pid  : '0;
  assign out_last    = out_valid & head.last;
endmodule
